// File: rtl/snake_dir_input.sv
// snake_dir_input: synchronise, debounce and queue player turns, releasing one per game tick
module snake_dir_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       up,
  input  logic       right,
  input  logic       down,
  input  logic       left,
  input  logic       tick,
  output logic [2:0] move,
  output logic       move_changed,
  output logic [1:0] pending,
  output logic       dropped
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [3:0] s1_q, s1_d, s2_q, s2_d, db_q, db_d, dbp_q, dbp_d, ev_q, ev_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [2:0] q_q [2];
  logic [2:0] q_d [2];
  logic [2:0] move_q, move_d, last_q, last_d, dir;
  logic [1:0] occ_q, occ_d, occ_pop;
  logic chg_q, chg_d, drop_q, drop_d, pop, has_ev, opp, acc;
  always_comb begin
    s1_d = {left, down, right, up};
    s2_d = s1_q;
    dbp_d = db_q;
    ev_d = db_q & ~dbp_q;
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i] + CW'(1);
      if (s2_q[i] == db_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end
    end
    // bit order {left,down,right,up} makes the lowest set bit the highest priority
    dir = ev_q[0] ? 3'd1 : ev_q[1] ? 3'd2 : ev_q[2] ? 3'd3 : 3'd4;
    has_ev = |ev_q;
    pop = tick && occ_q != 2'd0;
    occ_pop = occ_q - {1'b0, pop};
    opp = last_q != 3'd5 && (dir == last_q + 3'd2 || last_q == dir + 3'd2);
    acc = has_ev && dir != last_q && !opp && occ_pop < 2'(FIFO_DEPTH);
    q_d[0] = pop ? q_q[1] : q_q[0];
    q_d[1] = q_q[1];
    if (acc && occ_pop == 2'd0) q_d[0] = dir;
    if (acc && occ_pop != 2'd0) q_d[1] = dir;
    occ_d = occ_pop + {1'b0, acc};
    last_d = acc ? dir : last_q;
    move_d = pop ? q_q[0] : move_q;
    chg_d = pop;
    drop_d = has_ev && !acc;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      dbp_q <= '0;
      ev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      q_q[0] <= '0;
      q_q[1] <= '0;
      occ_q <= '0;
      last_q <= 3'd5;
      move_q <= 3'd5;
      chg_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
      dbp_q <= dbp_d;
      ev_q <= ev_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      q_q[0] <= q_d[0];
      q_q[1] <= q_d[1];
      occ_q <= occ_d;
      last_q <= last_d;
      move_q <= move_d;
      chg_q <= chg_d;
      drop_q <= drop_d;
    end
  end
  assign move = move_q;
  assign move_changed = chg_q;
  assign pending = occ_q;
  assign dropped = drop_q;
endmodule

// File: tb/tb_snake_dir_input.sv
// tb_snake_dir_input: directed test-plan scenarios plus random button/tick traffic against a behavioural model
module tb_snake_dir_input;
  localparam int D = 4;
  logic clock = 1'b0, reset = 1'b1, up = 1'b0, right = 1'b0, down = 1'b0, left = 1'b0, tick = 1'b0;
  logic [2:0] move;
  logic move_changed, dropped;
  logic [1:0] pending;
  int checks = 0, errors = 0, drop_seen = 0;
  bit chk_en = 1'b0;
  snake_dir_input #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .up(up), .right(right), .down(down), .left(left),
    .tick(tick), .move(move), .move_changed(move_changed), .pending(pending), .dropped(dropped)
  );
  always #5 clock = ~clock;
  // Model: pins seen through a 2-sample history, a level accepted after D mismatching samples,
  // presses seen one cycle after the accepted level rises, turns held in a plain queue.
  logic [3:0] ph1, ph2, m_db, db_a, db_b;
  int run [4];
  int mq[$];
  int mv = 5, last = 5, m_chg = 0, m_drp = 0;
  always @(posedge clock) begin
    logic [3:0] s, ev;
    int d;
    if (reset) begin
      ph1 = '0; ph2 = '0; m_db = '0; db_a = '0; db_b = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      mq.delete();
      mv = 5; last = 5; m_chg = 0; m_drp = 0;
    end else begin
      s = ph2;
      ev = db_a & ~db_b;
      db_b = db_a;
      db_a = m_db;
      for (int i = 0; i < 4; i++) begin
        if (s[i] != m_db[i]) begin
          run[i]++;
          if (run[i] == D) begin m_db[i] = s[i]; run[i] = 0; end
        end else run[i] = 0;
      end
      ph2 = ph1;
      ph1 = {left, down, right, up};
      m_chg = (tick && mq.size() > 0) ? 1 : 0;
      if (m_chg == 1) mv = mq.pop_front();
      m_drp = 0;
      if (ev != 0) begin
        d = ev[0] ? 1 : ev[1] ? 2 : ev[2] ? 3 : 4;
        if (d != last && !(last != 5 && (d - last == 2 || last - d == 2)) && mq.size() < 2) begin
          mq.push_back(d);
          last = d;
        end else m_drp = 1;
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clock) begin
    if (chk_en) begin
      chk("move", int'(move), mv);
      chk("move_changed", int'(move_changed), m_chg);
      chk("pending", int'(pending), mq.size());
      chk("dropped", int'(dropped), m_drp);
      if (dropped === 1'b1) drop_seen++;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic pins(input logic [3:0] v);
    {left, down, right, up} = v;
  endtask
  task automatic press(input logic [3:0] v);
    pins(v); cyc(8); pins(4'b0); cyc(8);
  endtask
  task automatic pulse_tick();
    tick = 1'b1; cyc(1); tick = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1; pins(4'b0); tick = 1'b0; cyc(2); reset = 1'b0;
  endtask
  initial begin
    int dc;
    cyc(2);
    chk_en = 1'b1;
    reset = 1'b0;
    chk("reset_move", int'(move), 5);
    chk("reset_pending", int'(pending), 0);
    pins(4'b0001); cyc(7);
    chk("up_pending_edge6", int'(pending), 0);
    cyc(1);
    chk("up_pending_edge7", int'(pending), 1);
    cyc(12); pins(4'b0); cyc(10);
    chk("up_no_drop", drop_seen, 0);
    pulse_tick();
    chk("tick_move_up", int'(move), 1);
    chk("tick_changed", int'(move_changed), 1);
    chk("tick_pending", int'(pending), 0);
    cyc(1);
    chk("changed_one_cycle", int'(move_changed), 0);
    pins(4'b0001); cyc(3); pins(4'b0); cyc(12);
    chk("glitch_pending", int'(pending), 0);
    chk("glitch_no_drop", drop_seen, 0);
    dc = drop_seen;
    press(4'b0100);
    chk("reverse_dropped", drop_seen - dc, 1);
    chk("reverse_pending", int'(pending), 0);
    chk("reverse_move", int'(move), 1);
    press(4'b0010); pulse_tick();
    chk("right_move", int'(move), 2);
    dc = drop_seen;
    press(4'b0100); press(4'b1000);
    chk("two_pending", int'(pending), 2);
    press(4'b0001);
    chk("full_dropped", drop_seen - dc, 1);
    pulse_tick();
    chk("pop1_move", int'(move), 3);
    pulse_tick();
    chk("pop2_move", int'(move), 4);
    chk("drained", int'(pending), 0);
    do_reset();
    dc = drop_seen;
    press(4'b1001);
    chk("simul_pending", int'(pending), 1);
    chk("simul_no_drop", drop_seen - dc, 0);
    pulse_tick();
    chk("simul_move", int'(move), 1);
    press(4'b0010); press(4'b0100);
    chk("pre_reset_pending", int'(pending), 2);
    pins(4'b0001); cyc(3);
    reset = 1'b1; pins(4'b0); cyc(1); reset = 1'b0;
    chk("midreset_move", int'(move), 5);
    chk("midreset_pending", int'(pending), 0);
    cyc(12);
    chk("midreset_no_event", int'(pending), 0);
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] v;
      v = {left, down, right, up};
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) v[i] = ~v[i];
      pins(v);
      tick = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    reset = 1'b0; tick = 1'b0; pins(4'b0); cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_dir_input.md
Name: snake_dir_input

Overview:
- Upstream conditioner for the snake engine's player move input.
- Takes the raw up/right/down/left push-buttons and produces a clean, registered direction code for the engine.
- Synchronises and debounces each button, turns presses into events, rejects illegal turns, and buffers up to two pending turns.
- Each buffered turn is released on the engine's game-step tick, so fast sequences (e.g. up then left within one step) are not lost.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a button level change is accepted (10 ms at 25 MHz; benches use 4).
- FIFO_DEPTH, 2, pending-turn queue depth (fixed at 2; not required to scale).

Ports:
- clock  input  1  single clock, same domain as the snake engine (VGA_CLK).
- reset  input  1  synchronous, active-high reset.
- up  input  1  raw button, asynchronous, active-high.
- right  input  1  raw button, asynchronous, active-high.
- down  input  1  raw button, asynchronous, active-high.
- left  input  1  raw button, asynchronous, active-high.
- tick  input  1  one-cycle pulse from the engine, marking the start of a game step.
- move  output  3  current direction: 1=up, 2=right, 3=down, 4=left, 5=idle/none.
- move_changed  output  1  one-cycle pulse when move is updated.
- pending  output  2  number of queued turns, 0..2.
- dropped  output  1  one-cycle pulse when a press event is rejected.

Behaviour:
- Reset (synchronous; applies equally mid-operation):
  - move=5, move_changed=0, pending=0, dropped=0, last_dir=5.
  - Queue, synchronisers, debounce counters, debounced levels and edge registers all cleared to 0.
- Synchroniser: 2 flops per button. s_x is the pin value delayed 2 cycles.
- Debounce, per button, counter cnt_x and level db_x:
  - If s_x==db_x: cnt_x<=0.
  - Else if cnt_x==DEBOUNCE_CYCLES-1: db_x<=s_x and cnt_x<=0.
  - Else: cnt_x<=cnt_x+1.
  - So db_x toggles only after DEBOUNCE_CYCLES consecutive mismatched cycles; any glitch back restarts the count.
- Press event: registered rising edge of db_x, valid the cycle after db_x rises. Releases (falling edges) generate no event.
- Simultaneous events in one cycle:
  - Only the highest-priority one is considered: up > right > down > left.
  - The others are discarded silently, with no dropped pulse.
- Acceptance of event direction d (compared against last_dir, the most recently accepted direction):
  - Reject if d==last_dir.
  - Reject if last_dir!=5 and d is opposite of last_dir (1<->3, 2<->4).
  - Reject if the queue is full after this cycle's pop.
  - Otherwise push d to the queue tail and set last_dir<=d.
  - A rejected event pulses dropped for one cycle; last_dir is unchanged.
- Pop on tick:
  - If the queue is non-empty, the head is popped: move<=head, move_changed=1 on the following cycle (registered with move).
  - If the queue is empty, move holds and there is no pulse.
- Tick and event in the same cycle:
  - The pop is evaluated first, freeing a slot.
  - The push is then checked against last_dir, which is unaffected by the pop.
  - Net pending is then unchanged.
- Invariant: when the queue is empty, last_dir==move.
- pending is registered and reflects the queue occupancy after the cycle's pop and push.
- Latency: pin rising at clock edge 0 and held stable gives pending increment at edge DEBOUNCE_CYCLES+3.
- Tick-to-move latency: 1 cycle.
- No wrap-around concerns beyond the 2-entry queue pointers. The debounce counter saturates by construction (resets at DEBOUNCE_CYCLES-1).
- A button held indefinitely produces exactly one event. A new event requires release (db low) then a fresh press.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then up held high for 20 cycles -> pending=1 at cycle 7, no dropped. Then tick -> move=1 and move_changed high one cycle; pending=0.
- Up glitch high 3 cycles then low -> db never rises; pending=0, dropped never asserted.
- move=1 (up), press down -> dropped pulses, pending=0, move stays 1. Then press right, tick -> move=2.
- move=1, press right then down (each debounced) before any tick -> pending=2 (down is legal relative to right). Two ticks give move=2 then move=3. A third press left while pending=2 and no tick -> dropped.
- up and left rise on the same cycle from idle -> only up is accepted; pending=1, no dropped. Tick gives move=1.
- pending=2 and reset asserted for 1 cycle mid-debounce -> next cycle move=5, pending=0. The in-progress press produces no event.
